// File: rtl/pet_uart_rx.sv
// 8N1 serial receiver for the UART_TXD_IN pin: 2-flop sync, mid-bit sampling deframer,
// and a small first-word-fall-through byte FIFO with sticky framing/overrun flags.
module pet_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun
);
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef logic [FIFO_AW:0] ptr_t;
    localparam ptr_t PtrOne = ptr_t'(1);

    typedef enum logic [2:0] {StWaitHi, StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rx_meta_q, rxs_q;
    logic            push_req, frame_set;

    ptr_t            wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem_q [Depth];
    logic            empty, full, push, pop, ovf_set;
    logic            frame_err_q, overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= StWaitHi;
            cnt_q     <= '0;
            bitn_q    <= '0;
            shreg_q   <= '0;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitn_q    <= bitn_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitn_d    = bitn_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            // Only leave WAITHI once the line is high, so a held-low line can't start a frame.
            StWaitHi: if (rxs_q) state_d = StIdle;
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    cnt_d   = CntHalf;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        state_d = StData;
                        cnt_d   = CntFull;
                        bitn_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    cnt_d   = CntFull;
                    if (bitn_q == 3'd7) state_d = StStop;
                    else                bitn_d  = bitn_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        push_req = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StWaitHi;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StWaitHi;
        endcase
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        pop     = rd_en && !empty;
        push    = push_req && (!full || pop);
        ovf_set = push_req && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            frame_err_q <= frame_set || (frame_err_q && !clr_err);
            overrun_q   <= ovf_set || (overrun_q && !clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shreg_q;
    end

    assign data_valid = !empty;
    assign data_out   = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pet_uart_rx.sv
// Self-checking bench for pet_uart_rx: drives 8N1 frames on rxd and checks popped bytes
// against a queue of expected bytes, plus flag and reset behaviour.
module tb_pet_uart_rx;
    localparam int unsigned Cpb = 16;

    logic       clk = 1'b0;
    logic       reset, rxd, rd_en, clr_err;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    pet_uart_rx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_AW     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // pop_cyc >= 0 raises rd_en for the edge ending cycle pop_cyc (154 = stop-sample edge).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_byte,
                              input int pop_cyc);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        if (expect_byte) exp_q.push_back(d);
        for (int c = 0; c < 10 * Cpb; c++) begin
            rxd   = frame[c / Cpb];
            rd_en = (c == pop_cyc);
            if (c == pop_cyc) begin
                n_cmp++;
                if (exp_q.size() == 0 || data_out !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL pop_on_push: got %h dv=%b, expected head %h", data_out,
                             data_valid, (exp_q.size() == 0) ? 8'hxx : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
        end
        rxd   = 1'b1;
        rd_en = 1'b0;
    endtask

    task automatic read_byte(input string name);
        int w;
        logic [7:0] exp;
        w = 0;
        while (!data_valid && w < 400) begin
            tick();
            w++;
        end
        n_cmp++;
        if (!data_valid) begin
            n_err++;
            $display("FAIL %s: got no data_valid, expected a byte", name);
        end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got unexpected byte %h, expected none", name, data_out);
        end else begin
            exp = exp_q.pop_front();
            if (data_out !== exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", name, data_out, exp);
            end
        end
        if (data_valid) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        idle(3);
        reset = 1'b0;
        tick();
        n_cmp += 4;
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_dv: got %b, expected 0", data_valid); end
        if (frame_err !== 1'b0)  begin n_err++; $display("FAIL rst_fe: got %b, expected 0", frame_err); end
        if (overrun !== 1'b0)    begin n_err++; $display("FAIL rst_ovr: got %b, expected 0", overrun); end
        if (data_out !== 8'h00)  begin n_err++; $display("FAIL rst_data: got %h, expected 00", data_out); end
        idle(4);
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1, 1'b1, -1);
        send_frame(8'hA3, 1'b1, 1'b1, -1);
        read_byte("basic_0");
        read_byte("basic_1");
        n_cmp += 3;
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty: got dv=%b, expected 0", data_valid); end
        if (frame_err !== 1'b0)  begin n_err++; $display("FAIL basic_fe: got %b, expected 0", frame_err); end
        if (overrun !== 1'b0)    begin n_err++; $display("FAIL basic_ovr: got %b, expected 0", overrun); end
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        n_cmp += 2;
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL glitch_dv: got %b, expected 0", data_valid); end
        if (frame_err !== 1'b0)  begin n_err++; $display("FAIL glitch_fe: got %b, expected 0", frame_err); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        rxd = 1'b0;
        idle(40);
        rxd = 1'b1;
        idle(4);
        n_cmp += 2;
        if (frame_err !== 1'b1)  begin n_err++; $display("FAIL ferr_set: got %b, expected 1", frame_err); end
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL ferr_nobyte: got dv=%b, expected 0", data_valid); end
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        read_byte("ferr_next");
        n_cmp++;
        if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b, expected 1", frame_err); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clr: got %b, expected 0", frame_err); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, (i <= 4), -1);
        n_cmp++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
        for (int i = 0; i < 4; i++) read_byte("ovr_read");
        n_cmp++;
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL ovr_empty: got dv=%b, expected 0", data_valid); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b, expected 0", overrun); end
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1, -1);
        send_frame(8'h05, 1'b1, 1'b1, 154);
        n_cmp++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL fullpop_ovr: got %b, expected 0", overrun); end
        for (int i = 0; i < 4; i++) read_byte("fullpop_read");
        n_cmp++;
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got dv=%b, expected 0", data_valid); end
    endtask

    task automatic test_back_to_back_reset();
        logic [9:0] frame;
        send_frame(8'hAA, 1'b1, 1'b1, -1);
        send_frame(8'hBB, 1'b1, 1'b1, -1);
        n_cmp++;
        if (data_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got dv=%b, expected 1", data_valid); end
        // Reset lands during data bit 7 of 0x99, so the rest of the frame stays high.
        frame = {1'b1, 8'h99, 1'b0};
        for (int c = 0; c < 10 * Cpb; c++) begin
            rxd   = frame[c / Cpb];
            reset = (c == 130);
            if (c == 131) begin
                exp_q.delete();
                n_cmp += 2;
                if (data_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_dv: got %b, expected 0", data_valid); end
                if (data_out !== 8'h00)  begin n_err++; $display("FAIL rstmid_data: got %h, expected 00", data_out); end
            end
            tick();
        end
        reset = 1'b0;
        rxd   = 1'b1;
        idle(40);
        n_cmp++;
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_nobyte: got dv=%b, expected 0", data_valid); end
        send_frame(8'h42, 1'b1, 1'b1, -1);
        read_byte("rstmid_next");
        n_cmp++;
        if (data_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_end: got dv=%b, expected 0", data_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
